// File: rtl/hdd_sd_bridge.sv
// Bridges IIgs HDD controller sector requests onto the hps_io SD block interface.
// Validates each request against the mounted image and aborts on timeout or remount.
module hdd_sd_bridge #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd14_000_000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        hdd_read,
    input  logic        hdd_write,
    input  logic [15:0] hdd_sector,
    input  logic        img_mounted,
    input  logic        img_readonly,
    input  logic [63:0] img_size,
    input  logic        sd_ack,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    output logic        cpu_wait,
    output logic        hdd_mounted,
    output logic        hdd_protect,
    output logic        hdd_error
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER} state_t;

    state_t      r_state;
    logic        r_rd_pend;
    logic        r_wr_pend;
    logic        r_ack_q;
    logic        r_is_wr;
    logic [23:0] r_cnt;
    logic [63:0] r_img_size;

    logic        w_ack_rise;
    logic        w_ack_fall;
    logic        w_timeout;
    logic        w_launch_wr;
    logic        w_in_range;
    logic        w_reject;

    assign w_ack_rise  = sd_ack & ~r_ack_q;
    assign w_ack_fall  = ~sd_ack & r_ack_q;
    assign w_timeout   = (r_cnt == TIMEOUT_CYCLES - 24'd1);
    assign w_launch_wr = ~r_rd_pend & r_wr_pend;
    // Byte offset widened to 64 bits so sector 16'hFFFF cannot wrap.
    assign w_in_range  = {39'b0, hdd_sector, 9'b0} < r_img_size;
    assign w_reject    = ~hdd_mounted | (w_launch_wr & hdd_protect) | ~w_in_range;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_rd_pend   <= 1'b0;
            r_wr_pend   <= 1'b0;
            r_ack_q     <= 1'b0;
            r_is_wr     <= 1'b0;
            r_cnt       <= '0;
            r_img_size  <= '0;
            sd_lba      <= '0;
            sd_rd       <= 1'b0;
            sd_wr       <= 1'b0;
            cpu_wait    <= 1'b0;
            hdd_mounted <= 1'b0;
            hdd_protect <= 1'b0;
            hdd_error   <= 1'b0;
        end else begin
            r_ack_q   <= sd_ack;
            // Default: accumulate pulses; branches below override when a bit is served.
            r_rd_pend <= r_rd_pend | hdd_read;
            r_wr_pend <= r_wr_pend | hdd_write;

            if (img_mounted) begin
                hdd_mounted <= (img_size != 64'd0);
                hdd_protect <= img_readonly;
                r_img_size  <= img_size;
            end

            case (r_state)
                S_IDLE: begin
                    if (r_rd_pend || r_wr_pend) begin
                        if (w_reject) begin
                            hdd_error <= 1'b1;
                            if (r_rd_pend) r_rd_pend <= hdd_read;
                            else           r_wr_pend <= hdd_write;
                        end else begin
                            sd_lba    <= {16'b0, hdd_sector};
                            sd_rd     <= ~w_launch_wr;
                            sd_wr     <= w_launch_wr;
                            r_is_wr   <= w_launch_wr;
                            cpu_wait  <= 1'b1;
                            hdd_error <= 1'b0;
                            r_cnt     <= '0;
                            r_state   <= S_REQ;
                        end
                    end
                end
                S_REQ, S_XFER: begin
                    r_cnt <= r_cnt + 24'd1;
                    if (img_mounted) begin
                        r_rd_pend <= hdd_read;
                        r_wr_pend <= hdd_write;
                        sd_rd     <= 1'b0;
                        sd_wr     <= 1'b0;
                        cpu_wait  <= 1'b0;
                        hdd_error <= 1'b1;
                        r_state   <= S_IDLE;
                    end else if (w_timeout) begin
                        // In XFER the served bit was already cleared at ack rise.
                        if (r_state == S_REQ) begin
                            if (r_is_wr) r_wr_pend <= hdd_write;
                            else         r_rd_pend <= hdd_read;
                        end
                        sd_rd     <= 1'b0;
                        sd_wr     <= 1'b0;
                        cpu_wait  <= 1'b0;
                        hdd_error <= 1'b1;
                        r_state   <= S_IDLE;
                    end else if (r_state == S_REQ && w_ack_rise) begin
                        if (r_is_wr) r_wr_pend <= hdd_write;
                        else         r_rd_pend <= hdd_read;
                        sd_rd   <= 1'b0;
                        sd_wr   <= 1'b0;
                        r_state <= S_XFER;
                    end else if (r_state == S_XFER && w_ack_fall) begin
                        cpu_wait <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/hdd_sd_bridge.md
HDD_SD_BRIDGE -- requirements
Module: hdd_sd_bridge

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 24'd14_000_000, clk_sys cycles allowed per SD operation before abort (about 1 s).
REQ-002 SHALL have port: clk_sys  in  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port: reset_n  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port: hdd_read  in  1  one-cycle sector read request from the IIgs HDD controller.
REQ-005 SHALL have port: hdd_write  in  1  one-cycle sector write request.
REQ-006 SHALL have port: hdd_sector  in  16  block number; stable while cpu_wait is high.
REQ-007 SHALL have port: img_mounted  in  1  one-cycle mount/eject pulse from hps_io, drive 0.
REQ-008 SHALL have port: img_readonly  in  1  image write-protect, valid with img_mounted.
REQ-009 SHALL have port: img_size  in  64  image size in bytes, valid with img_mounted.
REQ-010 SHALL have port: sd_ack  in  1  hps_io transfer acknowledge, drive 0.
REQ-011 SHALL have port: sd_lba  out  32  block address, {16'b0, latched sector}.
REQ-012 SHALL have port: sd_rd  out  1  SD read request level.
REQ-013 SHALL have port: sd_wr  out  1  SD write request level.
REQ-014 SHALL have port: cpu_wait  out  1  CPU stall while an operation is outstanding.
REQ-015 SHALL have port: hdd_mounted  out  1  valid image present.
REQ-016 SHALL have port: hdd_protect  out  1  image read-only.
REQ-017 SHALL have port: hdd_error  out  1  last request failed; sticky until next accepted request.

Function
REQ-018 SHALL latch hdd_read/hdd_write pulses into rd_pend/wr_pend; a pulse arriving in any state is never lost.
REQ-019 SHALL register sd_ack into ack_q; ack rise = sd_ack & ~ack_q; ack fall = ~sd_ack & ack_q.
REQ-020 SHALL implement FSM states IDLE, REQ, XFER.
REQ-021 IDLE: with pending set, the next edge launches the op: sd_lba <= {16'b0, hdd_sector}, cpu_wait <= 1, hdd_error <= 0, timeout counter <= 0, go to REQ.
REQ-022 SHALL make a hdd_read sampled at edge N produce sd_rd=1 and cpu_wait=1 after edge N+1.
REQ-023 Read pending has priority; if both pend, read launches first and the write launches from IDLE after the read completes.
REQ-024 Launch drives sd_rd=1 for a read, sd_wr=1 for a write; never both.
REQ-025 REQ: on ack rise, clear sd_rd/sd_wr and the served pending bit, go to XFER.
REQ-026 XFER: on ack fall, cpu_wait <= 0, go to IDLE.
REQ-027 Rejected requests (not mounted; write with hdd_protect=1; {hdd_sector,9'b0} >= img_size) SHALL clear the pending bit, set hdd_error=1, keep cpu_wait and sd_rd/sd_wr low, and stay in IDLE.
REQ-028 The timeout counter SHALL increment in REQ and XFER; on reaching TIMEOUT_CYCLES-1, clear sd_rd/sd_wr and the served pending bit, set cpu_wait=0 and hdd_error=1, and go to IDLE.
REQ-029 On img_mounted: hdd_mounted <= (img_size != 0) and hdd_protect <= img_readonly.
REQ-030 If img_mounted occurs in REQ or XFER, it SHALL abort: clear both pending bits, sd_rd/sd_wr and cpu_wait, set hdd_error=1, go to IDLE.
REQ-031 Abort SHALL take priority over timeout and ack events in the same cycle; timeout SHALL take priority over ack.
REQ-032 The size compare SHALL be 64-bit and unsigned; sector 16'hFFFF SHALL NOT wrap.

Reset
REQ-033 reset_n low SHALL asynchronously force: state IDLE; sd_rd, sd_wr, cpu_wait, hdd_error, hdd_mounted, hdd_protect = 0; sd_lba = 0; both pending bits, ack_q and timeout counter = 0.
REQ-034 Reset asserted mid-operation SHALL abandon the op with no further SD request after release.

Verification
REQ-035 Normal read: mount img_size=32 MB; pulse hdd_read with sector 0x0010; ack high 3 cycles later for 512 cycles, then low -> sd_lba=0x10, sd_rd high until ack rise, cpu_wait falls on the ack-fall edge, hdd_error=0.
REQ-036 Simultaneous read and write pulses with sector 5 -> read completes first, then sd_wr asserts with sd_lba=5; no lost request.
REQ-037 Protected write: mount with img_readonly=1; pulse hdd_write -> sd_wr never asserts, cpu_wait stays 0, hdd_error=1; a following valid read clears hdd_error at launch.
REQ-038 Range check: img_size=1024; read sector 2 -> rejected, hdd_error=1; read sector 1 -> accepted.
REQ-039 Timeout: TIMEOUT_CYCLES=100; ack never asserts -> sd_rd drops and cpu_wait falls 100 cycles after launch, hdd_error=1.
REQ-040 Abort and reset: img_mounted in XFER -> IDLE, cpu_wait=0, hdd_error=1; reset_n pulsed low in REQ -> all outputs 0 immediately, no request after release.
